// File: rtl/blink_sequencer.sv
// Pattern-memory LED sequencer: steps through loaded 8-bit words on rising edges of a selected counter bit.
// Define BLINK_SEQ_PINGPONG_EN to bounce between the first and last entry instead of wrapping.
module blink_sequencer #(
    parameter int DEPTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [COUNT_W-1:0]         currentCount,
    input  logic [3:0]                 tap,
    input  logic [7:0]                 pattern_data,
    input  logic                       load,
    input  logic                       clear,
    input  logic                       run_en,
    output logic [7:0]                 led_out,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic [$clog2(DEPTH):0]     len,
    output logic                       wrap_pulse,
    output logic                       ovf
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [IDX_W-1:0] IDX_ONE = 1;
    localparam logic [IDX_W:0]   LEN_ONE = 1;
    localparam logic [IDX_W:0]   LEN_MAX = DEPTH[IDX_W:0];

    logic [1:0]       state_q, state_d;
    logic [IDX_W:0]   len_q, len_d;
    logic [IDX_W-1:0] step_q, step_d;
    logic [7:0]       led_q, led_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             prev_q;
    logic             mem_we;
    logic [7:0]       mem_q [DEPTH];

    // Tap values beyond the counter width clamp onto its MSB.
    int               tap_clamped;
    logic [COUNT_W-1:0] tap_hit;
    logic             cur_bit;
    logic             tick;

    always_comb begin
        tap_clamped = int'(tap);
        if (tap_clamped >= COUNT_W) begin
            tap_clamped = COUNT_W - 1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < COUNT_W; gi++) begin : g_tap
            assign tap_hit[gi] = (tap_clamped == gi) && currentCount[gi];
        end
    endgenerate

    assign cur_bit = |tap_hit;
    assign tick    = cur_bit && !prev_q;

    logic [IDX_W:0]   last_idx;
    logic [IDX_W-1:0] step_n;
    logic             adv_wrap;

    assign last_idx = len_q - LEN_ONE;

`ifdef BLINK_SEQ_PINGPONG_EN
    logic dir_q, dir_d;
    logic dir_n;

    // dir_q = 1 means counting up; the direction flips on the tick that lands on an endpoint.
    always_comb begin
        step_n   = step_q;
        adv_wrap = 1'b0;
        dir_n    = dir_q;
        if (dir_q) begin
            if ({1'b0, step_q} >= last_idx) begin
                step_n   = '0;
                adv_wrap = 1'b1;
            end else begin
                step_n = step_q + IDX_ONE;
                if ({1'b0, step_n} == last_idx) begin
                    adv_wrap = 1'b1;
                    dir_n    = 1'b0;
                end
            end
        end else begin
            if (step_q == '0) begin
                step_n   = '0;
                adv_wrap = 1'b1;
                dir_n    = 1'b1;
            end else begin
                step_n = step_q - IDX_ONE;
                if (step_n == '0) begin
                    adv_wrap = 1'b1;
                    dir_n    = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        step_n   = step_q + IDX_ONE;
        adv_wrap = 1'b0;
        if ({1'b0, step_q} >= last_idx) begin
            step_n   = '0;
            adv_wrap = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        step_d  = step_q;
        led_d   = led_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        mem_we  = 1'b0;
`ifdef BLINK_SEQ_PINGPONG_EN
        dir_d   = dir_q;
`endif
        if (clear) begin
            state_d = ST_IDLE;
            len_d   = '0;
            step_d  = '0;
            led_d   = '0;
            ovf_d   = 1'b0;
`ifdef BLINK_SEQ_PINGPONG_EN
            dir_d   = 1'b1;
`endif
        end else begin
            if (load && (state_q != ST_RUN)) begin
                if (len_q < LEN_MAX) begin
                    mem_we = 1'b1;
                    len_d  = len_q + LEN_ONE;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    step_d = '0;
                    led_d  = '0;
                    // Start decision uses len before any load landing this cycle.
                    if (run_en && (len_q != '0)) begin
                        state_d = ST_RUN;
                        led_d   = mem_q[0];
`ifdef BLINK_SEQ_PINGPONG_EN
                        dir_d   = 1'b1;
`endif
                    end
                end
                ST_RUN: begin
                    if (!run_en) begin
                        state_d = ST_HOLD;
                    end else if (tick) begin
                        step_d = step_n;
                        led_d  = mem_q[step_n];
                        wrap_d = adv_wrap;
`ifdef BLINK_SEQ_PINGPONG_EN
                        dir_d  = dir_n;
`endif
                    end
                end
                ST_HOLD: begin
                    if (run_en) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    led_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            step_q  <= '0;
            led_q   <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            prev_q  <= 1'b0;
`ifdef BLINK_SEQ_PINGPONG_EN
            dir_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            step_q  <= step_d;
            led_q   <= led_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            prev_q  <= cur_bit;
`ifdef BLINK_SEQ_PINGPONG_EN
            dir_q   <= dir_d;
`endif
        end
    end

    // Pattern storage is never cleared; len alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[len_q[IDX_W-1:0]] <= pattern_data;
        end
    end

    assign led_out    = led_q;
    assign step_idx   = step_q;
    assign len        = len_q;
    assign wrap_pulse = wrap_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Scoreboard bench for blink_sequencer: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_blink_sequencer;

    localparam int DEPTH   = 8;
    localparam int COUNT_W = 12;
`ifdef BLINK_SEQ_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic [COUNT_W-1:0] currentCount;
    logic [3:0]         tap;
    logic [7:0]         pattern_data;
    logic               load;
    logic               clear;
    logic               run_en;
    logic [7:0]         led_out;
    logic [2:0]         step_idx;
    logic [3:0]         len;
    logic               wrap_pulse;
    logic               ovf;

    blink_sequencer #(.DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .currentCount (currentCount),
        .tap          (tap),
        .pattern_data (pattern_data),
        .load         (load),
        .clear        (clear),
        .run_en       (run_en),
        .led_out      (led_out),
        .step_idx     (step_idx),
        .len          (len),
        .wrap_pulse   (wrap_pulse),
        .ovf          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] led;
        logic [2:0] step;
        logic [3:0] len;
        logic       wrap;
        logic       ovf;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_vec++;
                if (led_out !== e.led || step_idx !== e.step || len !== e.len ||
                    wrap_pulse !== e.wrap || ovf !== e.ovf) begin
                    n_bad++;
                    $display("FAIL %s: got led=%h step=%0d len=%0d wrap=%b ovf=%b, want led=%h step=%0d len=%0d wrap=%b ovf=%b",
                             nm, led_out, step_idx, len, wrap_pulse, ovf, e.led, e.step, e.len, e.wrap, e.ovf);
                end else begin
                    $display("ok   %s: led=%h step=%0d len=%0d wrap=%b ovf=%b",
                             nm, led_out, step_idx, len, wrap_pulse, ovf);
                end
            end
        end
    end

    task automatic cyc(input logic [COUNT_W-1:0] cc, input logic ld, input logic [7:0] d,
                       input logic clr, input logic run, input logic r);
        currentCount = cc;
        load         = ld;
        pattern_data = d;
        clear        = clr;
        run_en       = run;
        rst          = r;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] led_e, input logic [2:0] st,
                              input logic [3:0] ln, input logic w, input logic o);
        exp_t e;
        e.led  = led_e;
        e.step = st;
        e.len  = ln;
        e.wrap = w;
        e.ovf  = o;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic quiet(input logic run);
        cyc('0, 1'b0, 8'h00, 1'b0, run, 1'b0);
    endtask

    task automatic tk(input logic run);
        cyc(12'h004, 1'b0, 8'h00, 1'b0, run, 1'b0);
    endtask

    task automatic ld(input logic [7:0] d);
        cyc('0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        cyc('0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        tap = 4'd2;
        cyc('0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc('0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_out("reset", 8'h00, 3'd0, 4'd0, 1'b0, 1'b0);
        quiet(1'b1);
        expect_out("run_empty", 8'h00, 3'd0, 4'd0, 1'b0, 1'b0);

        // Basic four-entry walk
        ld(8'h01); expect_out("load1", 8'h00, 3'd0, 4'd1, 1'b0, 1'b0);
        ld(8'h02); expect_out("load2", 8'h00, 3'd0, 4'd2, 1'b0, 1'b0);
        ld(8'h04); expect_out("load3", 8'h00, 3'd0, 4'd3, 1'b0, 1'b0);
        ld(8'h08); expect_out("load4", 8'h00, 3'd0, 4'd4, 1'b0, 1'b0);
        quiet(1'b1); expect_out("run_entry", 8'h01, 3'd0, 4'd4, 1'b0, 1'b0);
        tk(1'b1);    expect_out("tick1", 8'h02, 3'd1, 4'd4, 1'b0, 1'b0);
        cyc('0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        expect_out("run_load_ignored", 8'h02, 3'd1, 4'd4, 1'b0, 1'b0);
        tk(1'b1);    expect_out("tick2", 8'h04, 3'd2, 4'd4, 1'b0, 1'b0);
        quiet(1'b1);
        tk(1'b1);    expect_out("tick3", 8'h08, 3'd3, 4'd4, PP, 1'b0);
        quiet(1'b1); expect_out("tick3_after", 8'h08, 3'd3, 4'd4, 1'b0, 1'b0);
        tk(1'b1);    expect_out("tick4", PP ? 8'h04 : 8'h01, PP ? 3'd2 : 3'd0, 4'd4, ~PP, 1'b0);
        quiet(1'b1); expect_out("tick4_after", PP ? 8'h04 : 8'h01, PP ? 3'd2 : 3'd0, 4'd4, 1'b0, 1'b0);
        do_clear();  expect_out("clear_run", 8'h00, 3'd0, 4'd0, 1'b0, 1'b0);

        // Hold with coincident tick, then resume
        ld(8'h01); ld(8'h02); ld(8'h04); ld(8'h08);
        expect_out("reload", 8'h00, 3'd0, 4'd4, 1'b0, 1'b0);
        quiet(1'b1); expect_out("run_entry2", 8'h01, 3'd0, 4'd4, 1'b0, 1'b0);
        tk(1'b1); quiet(1'b1);
        tk(1'b1);    expect_out("at_step2", 8'h04, 3'd2, 4'd4, 1'b0, 1'b0);
        quiet(1'b1);
        tk(1'b0);    expect_out("hold_tick", 8'h04, 3'd2, 4'd4, 1'b0, 1'b0);
        quiet(1'b0); expect_out("held", 8'h04, 3'd2, 4'd4, 1'b0, 1'b0);
        quiet(1'b1); expect_out("resume", 8'h04, 3'd2, 4'd4, 1'b0, 1'b0);
        tk(1'b1);    expect_out("resume_tick", 8'h08, 3'd3, 4'd4, PP, 1'b0);
        quiet(1'b1); expect_out("resume_after", 8'h08, 3'd3, 4'd4, 1'b0, 1'b0);

        // Clear beats a coincident tick
        cyc(12'h004, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        expect_out("clear_tick", 8'h00, 3'd0, 4'd0, 1'b0, 1'b0);
        quiet(1'b1); expect_out("idle_empty", 8'h00, 3'd0, 4'd0, 1'b0, 1'b0);

        // Overflow: ninth load dropped, memory intact
        for (int k = 0; k < 8; k++) begin
            ld(8'h10 + 8'(k));
            expect_out($sformatf("fill%0d", k), 8'h00, 3'd0, 4'(k + 1), 1'b0, 1'b0);
        end
        ld(8'h18);   expect_out("overflow", 8'h00, 3'd0, 4'd8, 1'b0, 1'b1);
        quiet(1'b1); expect_out("full_entry", 8'h10, 3'd0, 4'd8, 1'b0, 1'b1);
        for (int k = 1; k < 8; k++) begin
            tk(1'b1);
            expect_out($sformatf("full_tick%0d", k), 8'h10 + 8'(k), 3'(k), 4'd8, (k == 7) ? PP : 1'b0, 1'b1);
            quiet(1'b1);
        end
        do_clear();  expect_out("clear_ovf", 8'h00, 3'd0, 4'd0, 1'b0, 1'b0);

        // Single entry: every tick wraps
        ld(8'h5A);   expect_out("len1_load", 8'h00, 3'd0, 4'd1, 1'b0, 1'b0);
        quiet(1'b1); expect_out("len1_entry", 8'h5A, 3'd0, 4'd1, 1'b0, 1'b0);
        tk(1'b1);    expect_out("len1_tick", 8'h5A, 3'd0, 4'd1, 1'b1, 1'b0);
        quiet(1'b1); expect_out("len1_after", 8'h5A, 3'd0, 4'd1, 1'b0, 1'b0);
        tk(1'b1);    expect_out("len1_tick2", 8'h5A, 3'd0, 4'd1, 1'b1, 1'b0);
        do_clear();

        // Out-of-range tap clamps to the counter MSB; a held-high bit gives one tick
        tap = 4'd14;
        ld(8'h33); ld(8'h66);
        quiet(1'b1); expect_out("tap_entry", 8'h33, 3'd0, 4'd2, 1'b0, 1'b0);
        tk(1'b1);    expect_out("tap_bit2_ignored", 8'h33, 3'd0, 4'd2, 1'b0, 1'b0);
        quiet(1'b1);
        cyc(12'h800, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        expect_out("tap_msb_tick", 8'h66, 3'd1, 4'd2, PP, 1'b0);
        quiet(1'b1);
        cyc(12'h800, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        expect_out("tap_msb_tick2", 8'h33, 3'd0, 4'd2, 1'b1, 1'b0);
        cyc(12'h800, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        expect_out("tap_level_no_tick", 8'h33, 3'd0, 4'd2, 1'b0, 1'b0);
        tap = 4'd2;
        do_clear();

        // Reset mid-run beats a coincident tick
        for (int k = 0; k < 6; k++) ld(8'h20 + 8'(k));
        quiet(1'b1); expect_out("six_entry", 8'h20, 3'd0, 4'd6, 1'b0, 1'b0);
        for (int k = 1; k < 6; k++) begin
            tk(1'b1);
            expect_out($sformatf("six_tick%0d", k), 8'h20 + 8'(k), 3'(k), 4'd6, (k == 5) ? PP : 1'b0, 1'b0);
            quiet(1'b1);
        end
        cyc(12'h004, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        expect_out("rst_mid_run", 8'h00, 3'd0, 4'd0, 1'b0, 1'b0);
        quiet(1'b1); expect_out("after_rst", 8'h00, 3'd0, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
